// File: rtl/lsu_pkg.sv
// lsu_pkg: state encodings and default sizing shared by the LSU cluster top and its lanes.
package lsu_pkg;

   localparam int LSU_NUM_LANES      = 4;
   localparam int LSU_ADDR_BITS      = 8;
   localparam int LSU_DATA_BITS      = 16;
   localparam int LSU_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      LANE_IDLE,
      LANE_REQ,
      LANE_RELEASE,
      LANE_DONE
   } lane_state_t;

   typedef enum logic [1:0] {
      TOP_IDLE,
      TOP_BUSY,
      TOP_RESP
   } top_state_t;

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: one memory-controller consumer port with its handshake FSM and load-data register.
// The per-lane watchdog exists only when LSU_TIMEOUT_EN is defined.
module lsu_lane
   import lsu_pkg::*;
#(
   parameter int ADDR_BITS      = LSU_ADDR_BITS,
   parameter int DATA_BITS      = LSU_DATA_BITS,
   parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_start,
   input  logic                 i_write,
   input  logic                 i_clear,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic [DATA_BITS-1:0] i_wdata,
   input  logic                 i_read_ready,
   input  logic [DATA_BITS-1:0] i_read_data,
   input  logic                 i_write_ready,
   output logic                 o_read_valid,
   output logic                 o_write_valid,
   output logic [ADDR_BITS-1:0] o_addr,
   output logic [DATA_BITS-1:0] o_wdata,
   output logic [DATA_BITS-1:0] o_rsp_data,
   output logic                 o_done,
   output logic                 o_timeout
);

   lane_state_t          r_state;
   lane_state_t          w_next;
   logic                 r_write;
   logic [ADDR_BITS-1:0] r_addr;
   logic [DATA_BITS-1:0] r_wdata;
   logic [DATA_BITS-1:0] r_rsp_data;
   logic                 r_read_valid;
   logic                 r_write_valid;
   logic                 w_ready;
   logic                 w_expired;
   logic                 w_timeout;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_BITS-1:0] r_cnt;
   logic                w_waiting;

   assign w_waiting = (r_state == LANE_REQ) || (r_state == LANE_RELEASE);
   assign w_expired = w_waiting && (r_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || i_start) begin
         r_cnt <= '0;
      end else if (w_waiting) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign w_expired = 1'b0;
`endif

   // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latch).
   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      w_ready   = r_write ? i_write_ready : i_read_ready;
      case (r_state)
         LANE_IDLE:    if (i_start) w_next = LANE_REQ;
         LANE_REQ: begin
            if (w_ready) begin
               w_next = LANE_RELEASE;
            end else if (w_expired) begin
               w_next    = LANE_DONE;
               w_timeout = 1'b1;
            end
         end
         // Wait for ready to fall so the controller's late-clearing ready is not a second acknowledge.
         LANE_RELEASE: begin
            if (!w_ready) begin
               w_next = LANE_DONE;
            end else if (w_expired) begin
               w_next    = LANE_DONE;
               w_timeout = 1'b1;
            end
         end
         LANE_DONE:    if (i_clear) w_next = LANE_IDLE;
         default:      w_next = LANE_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= LANE_IDLE;
         r_write       <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_rsp_data    <= '0;
         r_read_valid  <= 1'b0;
         r_write_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         if (i_start) begin
            r_write       <= i_write;
            r_addr        <= i_addr;
            r_wdata       <= i_wdata;
            r_read_valid  <= !i_write;
            r_write_valid <= i_write;
         end else if (w_next != LANE_REQ) begin
            r_read_valid  <= 1'b0;
            r_write_valid <= 1'b0;
         end
         if ((r_state == LANE_REQ) && w_ready && !r_write) begin
            r_rsp_data <= i_read_data;
         end
      end
   end

   assign o_read_valid  = r_read_valid;
   assign o_write_valid = r_write_valid;
   assign o_addr        = r_addr;
   assign o_wdata       = r_wdata;
   assign o_rsp_data    = r_rsp_data;
   assign o_done        = (r_state == LANE_DONE);
   assign o_timeout     = w_timeout;

endmodule

// File: rtl/lsu_cluster.sv
// lsu_cluster: fans one core load/store out to masked lanes, each a consumer of the shared memory
// controller, and returns a single response once all masked lanes finish. Option: LSU_TIMEOUT_EN.
module lsu_cluster
   import lsu_pkg::*;
#(
   parameter int NUM_LANES      = LSU_NUM_LANES,
   parameter int ADDR_BITS      = LSU_ADDR_BITS,
   parameter int DATA_BITS      = LSU_DATA_BITS,
   parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_write,
   input  logic [NUM_LANES-1:0]           req_mask,
   input  logic [NUM_LANES*ADDR_BITS-1:0] req_addr,
   input  logic [NUM_LANES*DATA_BITS-1:0] req_wdata,
   output logic                           rsp_valid,
   output logic [NUM_LANES*DATA_BITS-1:0] rsp_data,
   output logic                           rsp_err,
   output logic [NUM_LANES-1:0]           mem_read_valid,
   output logic [NUM_LANES*ADDR_BITS-1:0] mem_read_address,
   input  logic [NUM_LANES-1:0]           mem_read_ready,
   input  logic [NUM_LANES*DATA_BITS-1:0] mem_read_data,
   output logic [NUM_LANES-1:0]           mem_write_valid,
   output logic [NUM_LANES*ADDR_BITS-1:0] mem_write_address,
   output logic [NUM_LANES*DATA_BITS-1:0] mem_write_data,
   input  logic [NUM_LANES-1:0]           mem_write_ready
);

   top_state_t           r_state;
   top_state_t           w_next;
   logic [NUM_LANES-1:0] r_mask;
   logic [NUM_LANES-1:0] w_lane_done;
   logic [NUM_LANES-1:0] w_lane_timeout;
   logic                 w_accept;
   logic                 w_all_done;
   logic                 w_clear;

   assign w_accept   = req_valid && (r_state == TOP_IDLE);
   assign w_all_done = &(w_lane_done | ~r_mask);
   assign w_clear    = (r_state == TOP_RESP);

   always_comb begin
      w_next = r_state;
      case (r_state)
         TOP_IDLE: if (req_valid) w_next = TOP_BUSY;
         TOP_BUSY: if (w_all_done) w_next = TOP_RESP;
         TOP_RESP: w_next = TOP_IDLE;
         default:  w_next = TOP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= TOP_IDLE;
         r_mask  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) r_mask <= req_mask;
      end
   end

`ifdef LSU_TIMEOUT_EN
   logic r_err;

   // Sticky across the whole operation; only a new acceptance clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (|w_lane_timeout) begin
         r_err <= 1'b1;
      end
   end

   assign rsp_err = r_err;
`else
   assign rsp_err = 1'b0;
`endif

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [ADDR_BITS-1:0] w_addr;

      lsu_lane #(
         .ADDR_BITS      (ADDR_BITS),
         .DATA_BITS      (DATA_BITS),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_lane (
         .clk           (clk),
         .reset         (reset),
         .i_start       (w_accept && req_mask[g]),
         .i_write       (req_write),
         .i_clear       (w_clear),
         .i_addr        (req_addr[g*ADDR_BITS +: ADDR_BITS]),
         .i_wdata       (req_wdata[g*DATA_BITS +: DATA_BITS]),
         .i_read_ready  (mem_read_ready[g]),
         .i_read_data   (mem_read_data[g*DATA_BITS +: DATA_BITS]),
         .i_write_ready (mem_write_ready[g]),
         .o_read_valid  (mem_read_valid[g]),
         .o_write_valid (mem_write_valid[g]),
         .o_addr        (w_addr),
         .o_wdata       (mem_write_data[g*DATA_BITS +: DATA_BITS]),
         .o_rsp_data    (rsp_data[g*DATA_BITS +: DATA_BITS]),
         .o_done        (w_lane_done[g]),
         .o_timeout     (w_lane_timeout[g])
      );

      assign mem_read_address[g*ADDR_BITS +: ADDR_BITS]  = w_addr;
      assign mem_write_address[g*ADDR_BITS +: ADDR_BITS] = w_addr;
   end

   assign req_ready = (r_state == TOP_IDLE);
   assign rsp_valid = (r_state == TOP_RESP);

endmodule

// File: tb/tb_lsu_cluster.sv
// tb_lsu_cluster: directed steps with a response scoreboard; the bench plays the memory controller.
module tb_lsu_cluster;

   localparam int NL = 4;
   localparam int AB = 8;
   localparam int DB = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [NL-1:0]    req_mask;
   logic [NL*AB-1:0] req_addr;
   logic [NL*DB-1:0] req_wdata;
   logic             rsp_valid;
   logic [NL*DB-1:0] rsp_data;
   logic             rsp_err;
   logic [NL-1:0]    mem_read_valid;
   logic [NL*AB-1:0] mem_read_address;
   logic [NL-1:0]    mem_read_ready;
   logic [NL*DB-1:0] mem_read_data;
   logic [NL-1:0]    mem_write_valid;
   logic [NL*AB-1:0] mem_write_address;
   logic [NL*DB-1:0] mem_write_data;
   logic [NL-1:0]    mem_write_ready;

   lsu_cluster #(
      .NUM_LANES      (NL),
      .ADDR_BITS      (AB),
      .DATA_BITS      (DB),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_mask          (req_mask),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_data          (rsp_data),
      .rsp_err           (rsp_err),
      .mem_read_valid    (mem_read_valid),
      .mem_read_address  (mem_read_address),
      .mem_read_ready    (mem_read_ready),
      .mem_read_data     (mem_read_data),
      .mem_write_valid   (mem_write_valid),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .mem_write_ready   (mem_write_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NL*DB-1:0] data;
      logic             err;
   } exp_t;

   exp_t             sb[$];
   logic [NL*DB-1:0] model_rsp;
   int               total = 0;
   int               bad = 0;
   int               cyc = 0;
   int               acc_cyc = 0;
   int               valid_seen = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if ((|mem_read_valid) || (|mem_write_valid)) valid_seen <= valid_seen + 1;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic err);
      exp_t e;
      e.data = model_rsp;
      e.err  = err;
      sb.push_back(e);
   endtask

   task automatic issue(input logic wr, input logic [NL-1:0] mask,
                        input logic [NL*AB-1:0] addrs, input logic [NL*DB-1:0] wd);
      req_write = wr;
      req_mask  = mask;
      req_addr  = addrs;
      req_wdata = wd;
      req_valid = 1'b1;
      check("req_ready_idle", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      acc_cyc   = cyc;
   endtask

   // Waits for the response, compares it against the scoreboard head, checks latency when lat >= 0.
   task automatic finish_rsp(input string tag, input int lat);
      exp_t e;
      int   n = 0;
      while (!rsp_valid && n < 60) begin
         tick();
         n++;
      end
      if (!rsp_valid) begin
         check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
      end else if (sb.size() == 0) begin
         check({tag, "_unexpected_rsp"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_rsp_data"}, rsp_data, e.data);
         check({tag, "_rsp_err"}, rsp_err, e.err);
         if (lat >= 0) check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
         tick();
         check({tag, "_rsp_pulse"}, rsp_valid, 1'b0);
         check({tag, "_ready_back"}, req_ready, 1'b1);
      end
   endtask

   initial begin
      int lane;
      int served;
      int guard;
      int n;

      reset           = 1'b1;
      req_valid       = 1'b0;
      req_write       = 1'b0;
      req_mask        = '0;
      req_addr        = '0;
      req_wdata       = '0;
      mem_read_ready  = '0;
      mem_read_data   = '0;
      mem_write_ready = '0;
      model_rsp       = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_rsp_data", rsp_data, 64'd0);
      check("rst_rd_valid", mem_read_valid, 4'd0);
      check("rst_wr_valid", mem_write_valid, 4'd0);

      // Load lane 0, ready two cycles after valid
      model_rsp[0 +: DB] = 16'hBEEF;
      push_exp(1'b0);
      issue(1'b0, 4'b0001, 32'h0000_0010, '0);
      check("ld0_valid_t0", mem_read_valid, 4'b0001);
      check("ld0_addr_t0", mem_read_address[0 +: AB], 8'h10);
      tick();
      check("ld0_valid_t1", mem_read_valid, 4'b0001);
      tick();
      check("ld0_addr_t2", mem_read_address[0 +: AB], 8'h10);
      mem_read_ready[0]      = 1'b1;
      mem_read_data[0 +: DB] = 16'hBEEF;
      tick();
      check("ld0_valid_drop", mem_read_valid, 4'b0000);
      mem_read_ready[0] = 1'b0;
      mem_read_data     = '0;
      finish_rsp("ld0", 5);

      // Minimum latency: ready high at t0+1, low at t0+2
      model_rsp[2*DB +: DB] = 16'h1234;
      push_exp(1'b0);
      issue(1'b0, 4'b0100, 32'h0055_0000, '0);
      check("ld2_addr", mem_read_address[2*AB +: AB], 8'h55);
      mem_read_ready[2]         = 1'b1;
      mem_read_data[2*DB +: DB] = 16'h1234;
      tick();
      mem_read_ready[2] = 1'b0;
      mem_read_data     = '0;
      finish_rsp("ld2", 3);

      // Store on all lanes through a one-channel controller (lowest lane first, ready clears late)
      push_exp(1'b0);
      issue(1'b1, 4'b1111, 32'h2322_2120, 64'h4444_3333_2222_1111);
      check("st_rd_valid", mem_read_valid, 4'b0000);
      served = 0;
      guard  = 0;
      while (served < NL && guard < 200) begin
         guard++;
         lane = -1;
         for (int i = NL - 1; i >= 0; i--) if (mem_write_valid[i]) lane = i;
         if (lane < 0) begin
            tick();
         end else begin
            check("st_order", 64'(lane), 64'(served));
            check("st_addr", mem_write_address[lane*AB +: AB], 64'(8'h20 + lane));
            check("st_data", mem_write_data[lane*DB +: DB], 64'(16'h1111 * (lane + 1)));
            mem_write_ready[lane] = 1'b1;
            tick();
            check("st_valid_drop", mem_write_valid[lane], 1'b0);
            tick();
            mem_write_ready[lane] = 1'b0;
            served++;
         end
      end
      check("st_served", 64'(served), 64'(NL));
      finish_rsp("st", -1);

      // Empty mask
      valid_seen = 0;
      push_exp(1'b0);
      issue(1'b0, 4'b0000, 32'h0101_0101, '0);
      finish_rsp("mask0", 1);
      check("mask0_no_traffic", 64'(valid_seen), 64'd0);

      // Stale ready held three cycles after acknowledge
      model_rsp[1*DB +: DB] = 16'hCAFE;
      push_exp(1'b0);
      issue(1'b0, 4'b0010, 32'h0000_3300, '0);
      mem_read_ready[1]         = 1'b1;
      mem_read_data[1*DB +: DB] = 16'hCAFE;
      tick();
      mem_read_data[1*DB +: DB] = 16'hDEAD;
      for (int k = 0; k < 3; k++) begin
         check("stale_no_rereq", mem_read_valid, 4'b0000);
         check("stale_no_rsp", rsp_valid, 1'b0);
         tick();
      end
      mem_read_ready[1] = 1'b0;
      mem_read_data     = '0;
      finish_rsp("stale", 6);

      // Ready never arrives
      issue(1'b0, 4'b0001, 32'h0000_0077, '0);
`ifdef LSU_TIMEOUT_EN
      push_exp(1'b1);
      n = 0;
      while (mem_read_valid[0] && n < 50) begin
         n++;
         tick();
      end
      check("to_valid_cycles", 64'(n), 64'd8);
      finish_rsp("to", -1);
      push_exp(1'b0);
      issue(1'b0, 4'b0000, '0, '0);
      finish_rsp("to_err_clear", 1);
`else
      for (int k = 0; k < 100; k++) tick();
      check("to_still_busy", req_ready, 1'b0);
      check("to_valid_held", mem_read_valid, 4'b0001);
      check("to_no_err", rsp_err, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_rsp = '0;
`endif

      // Reset while busy with valids high
      issue(1'b0, 4'b1111, 32'h4343_4343, '0);
      check("rmid_valid", mem_read_valid, 4'b1111);
      reset = 1'b1;
      tick();
      check("rmid_rd_valid", mem_read_valid, 4'b0000);
      check("rmid_wr_valid", mem_write_valid, 4'b0000);
      check("rmid_rsp_valid", rsp_valid, 1'b0);
      reset = 1'b0;
      tick();
      model_rsp = '0;
      check("rmid_req_ready", req_ready, 1'b1);
      check("rmid_rsp_data", rsp_data, model_rsp);

      // Recovery after reset
      model_rsp[3*DB +: DB] = 16'h5A5A;
      push_exp(1'b0);
      issue(1'b0, 4'b1000, 32'h9900_0000, '0);
      mem_read_ready[3]         = 1'b1;
      mem_read_data[3*DB +: DB] = 16'h5A5A;
      tick();
      mem_read_ready[3] = 1'b0;
      mem_read_data     = '0;
      finish_rsp("recover", 3);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_cluster.md
Name: lsu_cluster

Overview:
- Per-core load/store unit cluster: one request lane per thread.
- Accepts a core-level load or store for a masked set of lanes.
- Drives each lane as one consumer port of the shared memory controller, which arbitrates consumers onto memory channels.
- Collects all lane completions, then returns a single response to the core.

Parameters:
NUM_LANES, 4, lanes (threads); equals the controller's consumer count for this core
ADDR_BITS, 8, address width
DATA_BITS, 16, data width
TIMEOUT_CYCLES, 255, per-lane watchdog limit; used only when LSU_TIMEOUT_EN is defined

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  core request
req_ready  out  1  high only in top state IDLE
req_write  in  1  1 = store, 0 = load
req_mask  in  NUM_LANES  lanes participating
req_addr  in  ADDR_BITS x NUM_LANES  per-lane address
req_wdata  in  DATA_BITS x NUM_LANES  per-lane store data
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DATA_BITS x NUM_LANES  per-lane load data
rsp_err  out  1  timeout flag, valid with rsp_valid
mem_read_valid  out  NUM_LANES  to controller consumer_read_valid
mem_read_address  out  ADDR_BITS x NUM_LANES
mem_read_ready  in  NUM_LANES
mem_read_data  in  DATA_BITS x NUM_LANES
mem_write_valid  out  NUM_LANES
mem_write_address  out  ADDR_BITS x NUM_LANES
mem_write_data  out  DATA_BITS x NUM_LANES
mem_write_ready  in  NUM_LANES

Behaviour:
- Reset: all outputs 0 except req_ready = 1. Top state IDLE, all lanes IDLE.
- Reset mid-operation aborts immediately; the controller shares the same reset.
- Top FSM:
  - IDLE -> BUSY on req_valid && req_ready. Latch req_write, req_mask, addresses and write data. Clear rsp_err.
  - BUSY -> RESP on the first clock edge where every masked lane is in DONE. Unmasked lanes count as done.
  - RESP: rsp_valid = 1 for exactly one cycle, all lanes return to IDLE. RESP -> IDLE.
  - req_valid while not IDLE is ignored; the caller holds its request.
- Lane FSM (masked lanes only):
  - IDLE -> REQ at acceptance.
  - REQ: the registered valid (read or write per req_write) goes high the cycle after acceptance. Address and data stay stable while valid is high.
  - REQ -> RELEASE when the matching ready is sampled 1. Valid drops next cycle; on a load, mem_read_data[lane] is captured into rsp_data[lane].
  - RELEASE -> DONE when ready is sampled 0. This blocks a stale ready (the controller clears ready one cycle after valid falls) from being taken as an acknowledge.
- rsp_data holds its value until the next load overwrites that lane. Stores and unmasked lanes leave rsp_data unchanged.
- A ready input on a lane not in REQ is ignored.
- Latency:
  - Acceptance edge t0, ready high at edge t0+1, low at t0+2: rsp_valid in cycle t0+4.
  - req_mask = 0: rsp_valid in cycle t0+2, with no memory traffic.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - Each lane has a counter, cleared on entry to REQ and incremented in REQ/RELEASE.
  - On reaching TIMEOUT_CYCLES the lane drops valid, goes to DONE and sets the sticky rsp_err. rsp_err is reported with rsp_valid and cleared on the next acceptance.
- Undefined: no counters, rsp_err tied 0, lanes wait indefinitely.

Decomposition:
- Package lsu_pkg: lane state enum (IDLE, REQ, RELEASE, DONE), top state enum (IDLE, BUSY, RESP), default width constants.
- Sub-module lsu_lane:
  - Holds the per-lane FSM, output registers and watchdog.
  - Instantiated NUM_LANES times.
  - Exports lane_done to the top FSM.

Test Plan:
- Load, mask 0001, addr 0x10; ready[0] high 2 cycles after valid, data 0xBEEF -> mem_read_address[0] = 0x10 held; rsp_data[0] = 0xBEEF; one rsp_valid pulse.
- Store, mask 1111, addr 0x20..0x23, data 0x1111..0x4444, through a 1-channel controller -> four writes at the correct addresses/data; one rsp_valid after the last ready falls.
- mask 0000 -> rsp_valid 2 cycles after acceptance; no read/write valid ever asserted.
- Stale ready: mem_read_ready[1] held high 3 cycles after acknowledge -> lane 1 stays in RELEASE; no second request; rsp_valid only after ready falls.
- Reset asserted while BUSY with valid high -> next cycle all valids 0, rsp_valid 0, req_ready 1 after reset release.
- TIMEOUT_CYCLES = 8, ready never asserted -> with LSU_TIMEOUT_EN: valid drops after 8 cycles, rsp_valid with rsp_err = 1. Without the macro: still BUSY after 100 cycles.
